// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the memory access stage: opcodes,
// funct3 encodings, the stage FSM state type and the access-alignment rule.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_state_e;

  // Access width comes from funct3[1:0]; 10 and 11 both count as word width.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] ofs);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = ofs[0];
      default: mis = (ofs != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Combinational load-data extraction: picks the addressed byte or halfword
// from the returned word and sign- or zero-extends it according to funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ofs,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension.
  always_comb begin
    byte_s = rdata[{ofs, 3'b000} +: 8];
    half_s = ofs[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ext = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ext = {24'h000000, byte_s};
      F3_H:    ext = {{16{half_s[15]}}, half_s};
      F3_HU:   ext = {16'h0000, half_s};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: passes ALU results through, runs the
// request/grant/response handshake for loads and stores, and registers the writeback bundle.
module mem_access_stage
  import riscv_pkg::*;
(
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_IR,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_RD2,
  output logic            mem_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_IR,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign
);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      ofs_q, ofs_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_ir_q, wb_ir_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_mis_q, wb_mis_d;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [1:0]      ofs_s;
  logic            is_mem_s;
  logic            is_store_s;
  logic            mis_s;
  logic [3:0]      st_be_s;
  logic [XLEN-1:0] st_wdata_s;
  logic [XLEN-1:0] ld_ext_s;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .ofs    (ofs_q),
    .funct3 (ir_q[14:12]),
    .ext    (ld_ext_s)
  );

  // Decode of the incoming bundle plus store lane alignment and byte enables.
  always_comb begin
    opcode_s   = ex_IR[6:0];
    funct3_s   = ex_IR[14:12];
    ofs_s      = ex_result[1:0];
    is_store_s = (opcode_s == OP_STORE);
    is_mem_s   = (opcode_s == OP_LOAD) || is_store_s;
    mis_s      = is_misaligned(funct3_s, ofs_s);
    case (funct3_s[1:0])
      2'b00: begin
        st_be_s    = 4'b0001 << ofs_s;
        st_wdata_s = {4{ex_RD2[7:0]}};
      end
      2'b01: begin
        st_be_s    = 4'b0011 << ofs_s;
        st_wdata_s = {2{ex_RD2[15:0]}};
      end
      default: begin
        st_be_s    = 4'b1111;
        st_wdata_s = ex_RD2;
      end
    endcase
  end

  // Next-state and writeback bundle computation.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ofs_d      = ofs_q;
    wb_valid_d = 1'b0;
    wb_ir_d    = wb_ir_q;
    wb_data_d  = wb_data_q;
    wb_mis_d   = wb_mis_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem_s && !mis_s) begin
            state_d = REQ;
            ir_d    = ex_IR;
            addr_d  = {ex_result[XLEN-1:2], 2'b00};
            we_d    = is_store_s;
            be_d    = is_store_s ? st_be_s : 4'b1111;
            wdata_d = is_store_s ? st_wdata_s : {XLEN{1'b0}};
            ofs_d   = ofs_s;
          end else begin
            wb_valid_d = 1'b1;
            wb_ir_d    = ex_IR;
            wb_data_d  = is_mem_s ? {XLEN{1'b0}} : ex_result;
            wb_mis_d   = is_mem_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_ir_d    = ir_q;
            wb_data_d  = {XLEN{1'b0}};
            wb_mis_d   = 1'b0;
          end else begin
            state_d = RSP;
          end
        end else begin
          state_d = REQ;
        end
      end
      RSP: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_ir_d    = ir_q;
          wb_data_d  = ld_ext_s;
          wb_mis_d   = 1'b0;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ir_q       <= {XLEN{1'b0}};
      addr_q     <= {XLEN{1'b0}};
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= {XLEN{1'b0}};
      ofs_q      <= 2'b00;
      wb_valid_q <= 1'b0;
      wb_ir_q    <= {XLEN{1'b0}};
      wb_data_q  <= {XLEN{1'b0}};
      wb_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ofs_q      <= ofs_d;
      wb_valid_q <= wb_valid_d;
      wb_ir_q    <= wb_ir_d;
      wb_data_q  <= wb_data_d;
      wb_mis_q   <= wb_mis_d;
    end
  end

  assign mem_busy    = (state_q != IDLE);
  assign dmem_req    = (state_q == REQ);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_IR       = wb_ir_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback bundles are queued
// when an instruction is issued and compared when wb_valid pulses.
module tb_mem_access_stage;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_IR = 32'h0, ex_result = 32'h0, ex_RD2 = 32'h0;
  logic        mem_busy, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid, wb_misalign;
  logic [31:0] wb_IR, wb_data;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb[$];

  mem_access_stage dut (
    .clk1(clk1), .rst_n(rst_n), .ex_valid(ex_valid), .ex_IR(ex_IR),
    .ex_result(ex_result), .ex_RD2(ex_RD2), .mem_busy(mem_busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_IR(wb_IR), .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  always #5 clk1 = ~clk1;

  // Writeback monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk1) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got IR=%h data=%h mis=%b, required no writeback", wb_IR, wb_data, wb_misalign);
      end else begin
        logic [64:0] exp_v;
        exp_v = sb.pop_front();
        if ({wb_IR, wb_data, wb_misalign} !== exp_v) begin
          errors++;
          $display("FAIL wb_bundle: got IR=%h data=%h mis=%b, required IR=%h data=%h mis=%b",
                   wb_IR, wb_data, wb_misalign, exp_v[64:33], exp_v[32:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the stage to be free, then presents one bundle for one edge.
  task automatic issue(input logic [31:0] ir, input logic [31:0] res, input logic [31:0] rd2, input bit keep);
    int n = 0;
    while (mem_busy !== 1'b0 && n < 50) begin
      @(posedge clk1); #1; n++;
    end
    checks++;
    if (mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL issue_wait: mem_busy=%b, required 0", mem_busy);
    end
    ex_valid = 1'b1; ex_IR = ir; ex_result = res; ex_RD2 = rd2;
    @(posedge clk1); #1;
    if (!keep) ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mem_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_IR, wb_data, wb_misalign} !== 105'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b req=%b wb_valid=%b wb_data=%h, required all 0", mem_busy, dmem_req, wb_valid, wb_data);
    end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic test_alu();
    sb.push_back({32'h003100B3, 32'h00000055, 1'b0});
    issue(32'h003100B3, 32'h00000055, 32'h0, 1'b0);
    @(negedge clk1);
    checks++;
    if (dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_access: req=%b busy=%b, required 0 0", dmem_req, mem_busy);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_back_to_back();
    sb.push_back({32'h00208133, 32'h11111111, 1'b0});
    sb.push_back({32'h00418233, 32'h22222222, 1'b0});
    ex_valid = 1'b1; ex_IR = 32'h00208133; ex_result = 32'h11111111;
    @(posedge clk1); #1;
    ex_IR = 32'h00418233; ex_result = 32'h22222222;
    @(posedge clk1); #1;
    ex_valid = 1'b0;
    @(negedge clk1);
    @(posedge clk1); #1;
  endtask

  task automatic do_store(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rd2,
                          input int gd, input logic [3:0] exp_be, input logic [31:0] exp_wd, input bit keep);
    sb.push_back({ir, 32'h0, 1'b0});
    issue(ir, addr, rd2, keep);
    for (int i = 0; i <= gd; i++) begin
      dmem_gnt = (i == gd);
      if (i == gd) ex_valid = 1'b0;
      @(negedge clk1);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || mem_busy !== 1'b1 ||
          dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== exp_be || dmem_wdata !== exp_wd) begin
        errors++;
        $display("FAIL store_req: req=%b we=%b busy=%b addr=%h be=%b wdata=%h, required 1 1 1 %h %b %h",
                 dmem_req, dmem_we, mem_busy, dmem_addr, dmem_be, dmem_wdata, {addr[31:2], 2'b00}, exp_be, exp_wd);
      end
      @(posedge clk1); #1;
    end
    dmem_gnt = 1'b0;
    @(negedge clk1);
    checks++;
    if (dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL store_done: req=%b busy=%b, required 0 0", dmem_req, mem_busy);
    end
    @(posedge clk1); #1;
  endtask

  task automatic do_load(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rdata,
                         input int gd, input int rw, input logic [31:0] exp_data);
    sb.push_back({ir, exp_data, 1'b0});
    issue(ir, addr, 32'h0, 1'b0);
    for (int i = 0; i <= gd; i++) begin
      dmem_gnt = (i == gd);
      @(negedge clk1);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b1111 || dmem_addr !== {addr[31:2], 2'b00}) begin
        errors++;
        $display("FAIL load_req: req=%b we=%b be=%b addr=%h, required 1 0 1111 %h",
                 dmem_req, dmem_we, dmem_be, dmem_addr, {addr[31:2], 2'b00});
      end
      @(posedge clk1); #1;
    end
    dmem_gnt = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      dmem_rvalid = (i == rw);
      dmem_rdata  = (i == rw) ? rdata : 32'hDEADBEEF;
      @(negedge clk1);
      checks++;
      if (dmem_req !== 1'b0 || mem_busy !== 1'b1) begin
        errors++;
        $display("FAIL load_rsp_wait: req=%b busy=%b, required 0 1", dmem_req, mem_busy);
      end
      @(posedge clk1); #1;
    end
    dmem_rvalid = 1'b0;
    @(negedge clk1);
    @(posedge clk1); #1;
  endtask

  task automatic test_misalign();
    sb.push_back({32'h00002003, 32'h0, 1'b1});
    issue(32'h00002003, 32'h00002002, 32'h0, 1'b0);
    @(negedge clk1);
    checks++;
    if (dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL misalign_no_req: req=%b busy=%b, required 0 0", dmem_req, mem_busy);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_reset_in_flight();
    issue(32'h00000003, 32'h00002001, 32'h0, 1'b0);
    dmem_gnt = 1'b1;
    @(posedge clk1); #1;
    dmem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_IR, wb_data, wb_misalign} !== 105'h0) begin
      errors++;
      $display("FAIL reset_in_flight: busy=%b req=%b wb_valid=%b wb_IR=%h wb_data=%h, required all 0",
               mem_busy, dmem_req, wb_valid, wb_IR, wb_data);
    end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234F678;
    @(posedge clk1); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk1);
    checks++;
    if (wb_valid !== 1'b0 || mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: wb_valid=%b busy=%b, required 0 0", wb_valid, mem_busy);
    end
    @(posedge clk1); #1;
    do_load(32'h00002003, 32'h00003000, 32'hCAFEBABE, 1, 0, 32'hCAFEBABE);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    do_store(32'h00000023, 32'h00001003, 32'hAABBCCDD, 2, 4'b1000, 32'hDDDDDDDD, 1'b0);
    do_store(32'h00001023, 32'h00001002, 32'h00001234, 0, 4'b1100, 32'h12341234, 1'b0);
    do_store(32'h00002023, 32'h00001004, 32'h01020304, 3, 4'b1111, 32'h01020304, 1'b1);
    do_load(32'h00000003, 32'h00002001, 32'h1234F678, 0, 2, 32'hFFFFFFF6);
    do_load(32'h00004003, 32'h00002001, 32'h1234F678, 1, 2, 32'h000000F6);
    do_load(32'h00001003, 32'h00002002, 32'h8001ABCD, 0, 1, 32'hFFFF8001);
    do_load(32'h00005003, 32'h00002002, 32'h8001ABCD, 0, 0, 32'h00008001);
    test_misalign();
    test_reset_in_flight();
    repeat (3) @(posedge clk1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d writebacks outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its registered outputs: the instruction word, the ALU result and the rs2 operand.
- For loads and stores, runs a request/grant/response handshake with the data memory.
- Builds the byte enables, aligns store data, and sign- or zero-extends load data.
- Presents a registered writeback bundle and asserts a busy/stall signal toward upstream while a memory access is in flight.

Parameters:
- XLEN, 32, datapath, address and instruction width.
- OP_LOAD, 7'b0000011, load opcode.
- OP_STORE, 7'b0100011, store opcode.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute-stage bundle valid this cycle.
- ex_IR  in  32  instruction from execute stage.
- ex_result  in  32  ALU result (effective address for loads and stores).
- ex_RD2  in  32  rs2 value (store data).
- mem_busy  out  1  stall to upstream; the bundle is not accepted while high.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data, full word.
- wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction).
- wb_IR  out  32  instruction passed to writeback.
- wb_data  out  32  ALU result or extended load data.
- wb_misalign  out  1  misaligned-access flag for this instruction.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE.
  - All outputs are 0: mem_busy, dmem_*, wb_valid, wb_IR, wb_data, wb_misalign.
  - Any access in flight is abandoned with no wb_valid. A response arriving after reset is ignored.
- Acceptance: a bundle is accepted on a rising edge where ex_valid=1 and mem_busy=0.
- mem_busy = (state != IDLE). It is combinational from the state register.
- Decode uses the accepted IR:
  - opcode = IR[6:0].
  - funct3 = IR[14:12].
  - Offset ofs = ex_result[1:0].
- Non-memory instruction: state stays IDLE. On the next edge: wb_valid=1, wb_IR=IR, wb_data=ex_result, wb_misalign=0. Latency is 1 cycle.
- Misalignment rules:
  - Halfword (funct3[1:0]=01) requires ofs[0]=0.
  - Word (funct3[1:0]=10) requires ofs=00.
  - Misaligned load or store issues no request. Next edge: wb_valid=1, wb_misalign=1, wb_data=0.
- FSM states IDLE, REQ, RSP.
  - IDLE -> REQ on an accepted, aligned load or store. IR, address, we, be and wdata are latched.
  - REQ: dmem_req=1, with address, we, be and wdata held stable until dmem_gnt.
  - REQ with gnt and store: -> IDLE. wb_valid=1 on the next edge with wb_data=0. Store latency is 1 cycle after grant.
  - REQ with gnt and load: -> RSP. dmem_req drops on that edge.
  - RSP: waits for dmem_rvalid. On the rvalid edge: -> IDLE, wb_valid=1, wb_data=extended load data.
  - An rvalid seen in IDLE or REQ is ignored.
- Byte enables:
  - SB: 4'b0001<<ofs.
  - SH: 4'b0011<<ofs.
  - SW: 4'b1111.
  - Loads issue be=4'b1111.
- Store data:
  - SB replicates RD2[7:0] into all 4 lanes.
  - SH replicates RD2[15:0] into both halves.
  - SW uses RD2 unchanged.
- Load extraction: byte = rdata[8*ofs +: 8]; halfword = rdata[16*ofs[1] +: 16].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
  - funct3 values 011, 110, 111: treated as LW/SW-width, misalign rule for word.
- wb_valid is a single-cycle pulse. wb_IR, wb_data and wb_misalign hold their values until the next wb_valid.
- No bundle is accepted while in REQ or RSP. ex_valid is ignored while busy; upstream must hold its bundle stable.
- A new bundle may be accepted in the same cycle that IDLE is re-entered only on the following edge (mem_busy is still high during the completing cycle).

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OP_LOAD, OP_STORE.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state encoding typedef for IDLE/REQ/RSP.
- One sub-module, load_extend: purely combinational; inputs rdata, ofs, funct3; output the 32-bit extended value.
- Store-lane alignment and byte-enable generation stay inline.

Test Plan:
- ADD IR 0x003100B3, ex_result 0x00000055, ex_valid pulse -> next edge wb_valid=1, wb_data=0x55, no dmem_req, mem_busy stays 0.
- SB with ex_result 0x1003 and RD2 0xAABBCCDD, gnt asserted 2 cycles late -> dmem_req held 3 cycles, addr 0x1000, be 4'b1000, wdata 0xDDDDDDDD, mem_busy=1 throughout; wb_valid 1 cycle after gnt.
- LB at ex_result 0x2001, rdata 0x1234F678 with rvalid 3 cycles after gnt -> wb_data 0xFFFFFFF6. LBU at the same address gives 0x000000F6.
- LH at 0x2002 with rdata 0x8001ABCD -> wb_data 0xFFFF8001. LHU gives 0x00008001.
- LW at 0x2002 -> no dmem_req; next edge wb_valid=1, wb_misalign=1, wb_data=0.
- Reset asserted while in RSP, then rvalid=1 after reset is released -> all outputs 0 immediately, no wb_valid, state IDLE; the next load completes normally.
